// File: rtl/fixed_vector_accumulator.sv
// fixed_vector_accumulator
//   Streaming signed fixed-point vector accumulator. Sums IN_DEPTH consecutive
//   IN_SIZE-element input beats element-wise and emits one full-precision
//   result vector (bit growth, no rounding). The fractional width is carried
//   through unchanged, so the binary point stays at IN_FRAC_WIDTH.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   rst             in   asynchronous active-low reset
//   data_in         in   IN_SIZE x IN_WIDTH signed input vector
//   data_in_valid   in   input beat valid
//   data_in_ready   out  input beat accepted when valid & ready
//   data_out        out  IN_SIZE x OUT_WIDTH signed accumulated vector
//   data_out_valid  out  output vector valid
//   data_out_ready  in   downstream accepts when valid & ready
module fixed_vector_accumulator #(
    parameter  int IN_SIZE       = 3,
    parameter  int IN_WIDTH      = 8,
    parameter  int IN_FRAC_WIDTH = 3,
    parameter  int IN_DEPTH      = 4,
    localparam int OUT_WIDTH     = IN_WIDTH + $clog2(IN_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out [IN_SIZE],
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    localparam int               CNT_W    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

    if (IN_DEPTH < 1 || IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH >= IN_WIDTH) begin : g_param_check
        $error("fixed_vector_accumulator: invalid parameter set");
    end

    logic [CNT_W-1:0]            cnt;
    logic signed [OUT_WIDTH-1:0] acc [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] sum [IN_SIZE];
    logic                        last_cnt;
    logic                        accept;

    assign last_cnt = (cnt == LAST_CNT);

    // Only the closing beat of a group needs the output register, so it is the
    // only beat that can be stalled by a held result. The drain in the same
    // cycle frees the register, hence the combinational data_out_ready term.
    assign data_in_ready = !last_cnt || !data_out_valid || data_out_ready;
    assign accept        = data_in_valid && data_in_ready;

    // Size cast keeps signedness, so each element is sign-extended before the add.
    always_comb begin
        for (int i = 0; i < IN_SIZE; i++) begin
            sum[i] = acc[i] + OUT_WIDTH'(data_in[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            data_out_valid <= 1'b0;
            for (int i = 0; i < IN_SIZE; i++) begin
                acc[i]      <= '0;
                data_out[i] <= '0;
            end
        end else begin
            if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
            // A closing beat overrides the drain above, keeping valid high for
            // back-to-back results.
            if (accept) begin
                if (last_cnt) begin
                    for (int i = 0; i < IN_SIZE; i++) begin
                        data_out[i] <= sum[i];
                        acc[i]      <= '0;
                    end
                    data_out_valid <= 1'b1;
                    cnt            <= '0;
                end else begin
                    for (int i = 0; i < IN_SIZE; i++) begin
                        acc[i] <= sum[i];
                    end
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_vector_accumulator.sv
// Bench for fixed_vector_accumulator: one instance with IN_DEPTH=4 and one with
// IN_DEPTH=1 share the same stimulus; each has its own reference model built
// from stored beats that are summed when a group completes.
module tb_fixed_vector_accumulator;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] din [3];
    logic              in_valid;
    logic              out_ready;

    logic              rdy4, vld4, rdy1, vld1;
    logic signed [9:0] dout4 [3];
    logic signed [7:0] dout1 [3];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state, index 0 = depth-4 instance, 1 = depth-1 instance
    int depth [2] = '{4, 1};
    int grp   [2][4][3];
    int bcnt  [2];
    bit hold  [2];
    int out_vec [2][3];
    int nout  [2];

    always #5 clk = ~clk;

    fixed_vector_accumulator #(.IN_SIZE(3), .IN_WIDTH(8), .IN_FRAC_WIDTH(3), .IN_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(in_valid), .data_in_ready(rdy4),
        .data_out(dout4), .data_out_valid(vld4), .data_out_ready(out_ready)
    );

    fixed_vector_accumulator #(.IN_SIZE(3), .IN_WIDTH(8), .IN_FRAC_WIDTH(3), .IN_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(in_valid), .data_in_ready(rdy1),
        .data_out(dout1), .data_out_valid(vld1), .data_out_ready(out_ready)
    );

    function automatic int get_ready(int k);
        return (k == 0) ? int'(rdy4) : int'(rdy1);
    endfunction

    function automatic int get_valid(int k);
        return (k == 0) ? int'(vld4) : int'(vld1);
    endfunction

    function automatic int get_out(int k, int i);
        return (k == 0) ? int'(dout4[i]) : int'(dout1[i]);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            bcnt[k] = 0;
            hold[k] = 0;
            for (int i = 0; i < 3; i++) out_vec[k][i] = 0;
        end
    endtask

    task automatic drive(input bit v, input bit r, input int e0, input int e1, input int e2);
        in_valid  = v;
        out_ready = r;
        din[0]    = 8'(e0);
        din[1]    = 8'(e1);
        din[2]    = 8'(e2);
    endtask

    task automatic drive_rand(input bit v, input bit r);
        drive(v, r, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    // One clock: check ready before the edge, update the model at the edge,
    // check the output register on the following falling edge.
    task automatic tick();
        bit acc [2];
        bit drn [2];
        bit exp_rdy;
        #1;
        if (!rst) model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_rdy = (bcnt[k] != depth[k] - 1) || !hold[k] || out_ready;
            check($sformatf("in_ready[d%0d]", depth[k]), get_ready(k), int'(exp_rdy));
            acc[k] = rst && in_valid && exp_rdy;
            drn[k] = rst && hold[k] && out_ready;
            if (drn[k]) nout[k]++;
        end
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (drn[k]) hold[k] = 0;
                if (acc[k]) begin
                    for (int i = 0; i < 3; i++) grp[k][bcnt[k]][i] = int'(din[i]);
                    bcnt[k]++;
                    if (bcnt[k] == depth[k]) begin
                        for (int i = 0; i < 3; i++) begin
                            out_vec[k][i] = 0;
                            for (int b = 0; b < depth[k]; b++) out_vec[k][i] += grp[k][b][i];
                        end
                        hold[k] = 1;
                        bcnt[k] = 0;
                    end
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid[d%0d]", depth[k]), get_valid(k), int'(hold[k]));
            for (int i = 0; i < 3; i++) begin
                check($sformatf("data_out[d%0d][%0d]", depth[k], i), get_out(k, i), out_vec[k][i]);
            end
        end
    endtask

    initial begin
        int s;
        rst = 1'b0;
        drive_rand(1'b1, 1'b0);
        model_reset();
        nout = '{0, 0};

        // reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_rand($urandom_range(0, 1), $urandom_range(0, 1));
            tick();
        end
        check("reset_valid4", int'(vld4), 0);
        check("reset_ready4", int'(rdy4), 1);
        check("reset_dout4_0", int'(dout4[0]), 0);
        rst = 1'b1;
        drive(1'b0, 1'b1, 0, 0, 0);
        tick();

        // basic sum 1+2+3+4 on element 0
        for (int b = 1; b <= 4; b++) begin
            drive(1'b1, 1'b1, b, $urandom_range(0, 255), $urandom_range(0, 255));
            tick();
            if (b == 1) begin
                check("d1_passthru_valid", int'(vld1), 1);
                check("d1_passthru_data", int'(dout1[0]), 1);
            end
        end
        check("basic_sum_valid", int'(vld4), 1);
        check("basic_sum", int'(dout4[0]), 10);

        // extreme values without wrap
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 1'b1, -128, -128, -128);
            tick();
        end
        check("sum_min", int'(dout4[1]), -512);
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 1'b1, 127, 127, 127);
            tick();
        end
        check("sum_max", int'(dout4[2]), 508);

        // backpressure: hold a result, stall the closing beat of the next group
        for (int b = 0; b < 4; b++) begin
            drive_rand(1'b1, 1'b1);
            tick();
        end
        for (int b = 0; b < 3; b++) begin
            drive_rand(1'b1, 1'b0);
            tick();
        end
        drive_rand(1'b1, 1'b0);
        #1;
        check("stall_last_beat", int'(rdy4), 0);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        check("drain_and_load_valid", int'(vld4), 1);
        drive(1'b0, 1'b1, 0, 0, 0);
        tick();
        tick();

        // full throughput
        nout = '{0, 0};
        for (int b = 0; b < 40; b++) begin
            drive_rand(1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1, 0, 0, 0);
        tick();
        check("throughput_d4", nout[0], 10);
        check("throughput_d1", nout[1], 40);

        // reset part-way through a group
        for (int b = 0; b < 2; b++) begin
            drive(1'b1, 1'b1, 50, 50, 50);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 1'b1, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        s = 0;
        for (int b = 5; b <= 8; b++) begin
            drive(1'b1, 1'b1, b, -b, 0);
            s += b;
            tick();
        end
        check("post_reset_sum", int'(dout4[0]), s);
        check("post_reset_sum_neg", int'(dout4[1]), -s);

        // random valid/ready with gaps on both sides
        for (int c = 0; c < 300; c++) begin
            drive_rand($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            tick();
        end
        drive(1'b0, 1'b1, 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
